// File: rtl/cond_unit.sv
// Condition unit for the single-cycle ARM datapath: holds NZCV, evaluates the
// instruction condition field and gates the decoder's state-changing strobes.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         ALLOW_NV    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic [3:0] flags
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;
  assign flags        = flags_q;

  // Only the registered flags are consulted, so an instruction never sees its own ALU result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cond_ex = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = ALLOW_NV;
    endcase
  end

  // N,Z and C,V halves update independently, and only for condition-passing instructions.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex) begin
      if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= RESET_FLAGS;
    else       flags_q <= flags_d;
  end

  // Commit strobes are held low while reset is asserted; cond_ex stays visible.
  always_comb begin
    pc_src    = !reset & pcs   & cond_ex;
    reg_write = !reset & reg_w & cond_ex & !no_write;
    mem_write = !reset & mem_w & cond_ex;
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit: reset, flag updates, condition
// table sweep, strobe gating and asynchronous reset.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs, reg_w, mem_w, no_write;
  logic       pc_src, reg_write, mem_write, cond_ex;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  cond_unit dut (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .cond_ex   (cond_ex),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
    $fatal(1, "watchdog");
  end

  // Independent reference of the ARM condition table (ALLOW_NV left at 0).
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (c)
      4'h0: return fz;
      4'h1: return ~fz;
      4'h2: return fc;
      4'h3: return ~fc;
      4'h4: return fn;
      4'h5: return ~fn;
      4'h6: return fv;
      4'h7: return ~fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn ~^ fv;
      4'hB: return fn ^ fv;
      4'hC: return !fz && (fn ~^ fv);
      4'hD: return fz || (fn ^ fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    cond = 4'hE; alu_flags = 4'h0; flag_w = 2'b00;
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
  endtask

  // Stimulus only: writes v into the flag register through an AL instruction.
  task automatic load_flags(input logic [3:0] v);
    @(negedge clk);
    idle_inputs();
    flag_w = 2'b11; alu_flags = v;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cond = 4'h0; reg_w = 1'b1; pcs = 1'b1; mem_w = 1'b1;
    #2;
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL reset_eq: got %b want 0", cond_ex); end
    cond = 4'h1;
    #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL reset_ne: got %b want 1", cond_ex); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
    checks++; if (pc_src !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got pc_src=%b mem_write=%b want 0 0", pc_src, mem_write);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_cmp_equal();
    @(negedge clk);
    cond = 4'hE; flag_w = 2'b11; no_write = 1'b1; alu_flags = 4'b0110; reg_w = 1'b1;
    #1;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL cmp_reg_write: got %b want 0", reg_write); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL cmp_flags_before: got %b want 0000", flags); end
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL cmp_flags_after: got %b want 0110", flags); end
    idle_inputs();
    cond = 4'h0; reg_w = 1'b1;
    #1;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL cmp_eq_reg_write: got %b want 1", reg_write); end
    idle_inputs();
  endtask

  task automatic test_partial_update();
    load_flags(4'b1001);
    @(negedge clk);
    cond = 4'hE; flag_w = 2'b10; alu_flags = 4'b0110;
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL partial_nz: got %b want 0101", flags); end
    @(negedge clk);
    cond = 4'hE; flag_w = 2'b01; alu_flags = 4'b1010;
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL partial_cv: got %b want 0110", flags); end
    @(negedge clk);
    cond = 4'hE; flag_w = 2'b00; alu_flags = 4'b1001;
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL hold_fw00: got %b want 0110", flags); end
    idle_inputs();
  endtask

  task automatic test_suppressed();
    load_flags(4'b0000);
    @(negedge clk);
    cond = 4'h0; flag_w = 2'b11; alu_flags = 4'b1111; mem_w = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL supp_mem_write: got %b want 0", mem_write); end
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL supp_flags: got %b want 0000", flags); end
    idle_inputs();
  endtask

  task automatic test_cond_sweep();
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        checks++;
        if (cond_ex !== ref_cond(4'(c), 4'(f))) begin
          errors++;
          $display("FAIL sweep flags=%b cond=%b: got %b want %b", 4'(f), 4'(c), cond_ex, ref_cond(4'(c), 4'(f)));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_signed_and_branch();
    load_flags(4'b1000);
    cond = 4'hA; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL ge_n1v0: got %b want 0", cond_ex); end
    cond = 4'hB; #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL lt_n1v0: got %b want 1", cond_ex); end
    cond = 4'hC; #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL gt_n1v0: got %b want 0", cond_ex); end
    cond = 4'hD; #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL le_n1v0: got %b want 1", cond_ex); end
    cond = 4'hE; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1; #1;
    checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL al_pc_src: got %b want 1", pc_src); end
    checks++; if (reg_write !== 1'b1 || mem_write !== 1'b1) begin
      errors++; $display("FAIL al_strobes: got reg_write=%b mem_write=%b want 1 1", reg_write, mem_write);
    end
    cond = 4'hF; #1;
    checks++; if (pc_src !== 1'b0 || cond_ex !== 1'b0) begin
      errors++; $display("FAIL nv_blocked: got pc_src=%b cond_ex=%b want 0 0", pc_src, cond_ex);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    load_flags(4'b0000);
    @(negedge clk);
    cond = 4'h1; flag_w = 2'b11; alu_flags = 4'b0100;
    #1;
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL b2b_old_read: got %b want 1", cond_ex); end
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL b2b_new_flags: got %b want 0100", flags); end
    alu_flags = 4'b0000;
    #1;
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL b2b_ne_after: got %b want 0", cond_ex); end
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL b2b_blocked: got %b want 0100", flags); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    realtime t0;
    load_flags(4'b1111);
    @(negedge clk);
    cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b1010; reg_w = 1'b1;
    #2;
    t0 = $realtime;
    reset = 1'b1;
    #1;
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL async_clear: got %b want 0000", flags); end
    checks++; if (clk !== 1'b0 || ($realtime - t0) > 2.0) begin
      errors++; $display("FAIL async_no_edge: got clk=%b want 0", clk);
    end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL async_reg_write: got %b want 0", reg_write); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL post_reset_update: got %b want 1010", flags); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_cmp_equal();
    test_partial_update();
    test_suppressed();
    test_cond_sweep();
    test_signed_and_branch();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer end of the ALU flag interface in the single-cycle ARM datapath.
- Holds the architectural NZCV status register, which is updated from the ALU flag outputs.
- Evaluates the 4-bit ARM condition field of the current instruction against the stored flags.
- Gates the decoder's PCSrc, RegWrite and MemWrite strobes so that only condition-passing instructions commit state.

Parameters:
- RESET_FLAGS, 4'b0000, reset value of {N,Z,C,V}.
- ALLOW_NV, 0, when 1 condition 4'b1111 executes unconditionally; when 0 it never executes.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears the flag register to RESET_FLAGS.
- cond  input  4  instruction bits [31:28].
- alu_flags  input  4  {N,Z,CO,V} from the ALU, current cycle.
- flag_w  input  2  [1]: write N,Z; [0]: write C,V (S-bit decode, per-op split).
- pcs  input  1  decoder PC-source request (branch or write to R15).
- reg_w  input  1  decoder register-write request.
- mem_w  input  1  decoder memory-write request.
- no_write  input  1  compare-class op (CMP/CMN/TST); suppresses reg_write.
- pc_src  output  1  gated pcs.
- reg_write  output  1  gated reg_w.
- mem_write  output  1  gated mem_w.
- cond_ex  output  1  condition passed.
- flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- Flag register: 4 flops, asynchronous clear to RESET_FLAGS on reset high. The default reset value is 0000.
- Register updates on the rising clk edge only when cond_ex=1:
  - N,Z <= alu_flags[3:2] if flag_w[1].
  - C,V <= alu_flags[1:0] if flag_w[0].
  - Each half is independent. A failed condition updates nothing.
- cond_ex is combinational from cond and the registered flags. It never uses alu_flags of the same cycle, so an instruction sees the flags of prior instructions only.
- Condition table (cond -> pass when):
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C&!Z.
  - 1001 LS: !C|Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: ALLOW_NV.
- Output gating (all combinational, zero latency):
  - pc_src = pcs & cond_ex.
  - reg_write = reg_w & cond_ex & !no_write.
  - mem_write = mem_w & cond_ex.
- Reset values: flags=RESET_FLAGS. While reset is high, pc_src, reg_write and mem_write are forced to 0 regardless of inputs, and cond_ex still reflects the table.
- Reset asserted mid-instruction: flags clear immediately (asynchronous), with no partial update. Release is synchronous to the next edge, and the first post-reset edge may update flags normally.
- A simultaneous flag write and condition read in the same cycle resolves as old flags for the read and new flags after the edge.
- flag_w=00 with cond_ex=1: register holds its value.

Test Plan:
- Reset → flags=0000.
  - cond=0000 (EQ) → cond_ex=0.
  - cond=0001 (NE) → cond_ex=1.
  - reg_w=1 with reset held → reg_write=0.
- CMP equal: cond=1110, flag_w=11, no_write=1, alu_flags=0110, reg_w=1.
  - During the cycle → reg_write=0.
  - After the edge → flags=0110.
  - Next cycle, cond=0000, reg_w=1 → reg_write=1.
- Partial update: flags=1001, cond=1110, flag_w=10, alu_flags=0110 → after the edge flags=0101 (C,V preserved).
- Suppressed update: flags=0000, cond=0000, flag_w=11, alu_flags=1111, mem_w=1 → mem_write=0, flags stay 0000.
- Signed compares and unconditional branch:
  - Sweep all 16 flag values × 16 cond values → cond_ex matches the table exactly.
  - With flags N=1, V=0: GE → 0, LT → 1, GT → 0, LE → 1.
  - With pcs=1, cond=1110 → pc_src=1.
- Async reset mid-cycle: flags=1111, assert reset between edges → flags=0000 within the same cycle, with no clk edge needed.
